// File: rtl/fir_pkg.sv
// Shared FIR datapath package: default widths and adder-tree sizing helpers.
package fir_pkg;

   localparam int unsigned DefInDatawidth = 8;
   localparam int unsigned DefNInputs     = 4;

   // Full-precision width of a sum of n operands of width w.
   function automatic int unsigned add_width(input int unsigned w, input int unsigned n);
      return w + $clog2(n);
   endfunction

   // Node count remaining after l pairwise tree levels.
   function automatic int unsigned level_nodes(input int unsigned n, input int unsigned l);
      return (n + (32'd1 << l) - 32'd1) >> l;
   endfunction

endpackage

// File: rtl/pipelined_adder_tree_if.sv
// Operand/sum valid-ready bundle for the pipelined adder tree.
interface pipelined_adder_tree_if
   import fir_pkg::*;
#(
   parameter int unsigned IN_DATAWIDTH = DefInDatawidth,
   parameter int unsigned N_INPUTS     = DefNInputs
);

   localparam int unsigned OUT_DATAWIDTH = add_width(IN_DATAWIDTH, N_INPUTS);

   logic [N_INPUTS*IN_DATAWIDTH-1:0] in_data;
   logic                             cin;
   logic                             in_valid;
   logic                             in_ready;
   logic [OUT_DATAWIDTH-1:0]         sum;
   logic                             out_valid;
   logic                             out_ready;

   modport master (
      output in_data, cin, in_valid, out_ready,
      input  in_ready, sum, out_valid
   );

   modport slave (
      input  in_data, cin, in_valid, out_ready,
      output in_ready, sum, out_valid
   );

endinterface

// File: rtl/adder_tree_stage.sv
// One adder-tree level: pairwise extended adds, odd trailing node passed through,
// result registered under a load enable.
module adder_tree_stage
   import fir_pkg::*;
#(
   parameter int unsigned IN_W    = 8,
   parameter int unsigned N_NODES = 4,
   parameter bit          SIGNED  = 1'b0,
   localparam int unsigned OUT_W  = IN_W + 1,
   localparam int unsigned N_OUT  = level_nodes(N_NODES, 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en_i,
   input  logic                   cin_i,
   input  logic [N_NODES*IN_W-1:0] data_i,
   output logic [N_OUT*OUT_W-1:0]  data_o
);

   logic [N_OUT*OUT_W-1:0] data_d, data_q;

   function automatic logic [OUT_W-1:0] ext(input logic [IN_W-1:0] x);
      return {SIGNED & x[IN_W-1], x};
   endfunction

   // One extra bit per level means neither the pair sum nor the carry-in can overflow.
   always_comb begin
      data_d = '0;
      for (int unsigned j = 0; j < N_NODES / 2; j++) begin
         data_d[j*OUT_W +: OUT_W] = ext(data_i[2*j*IN_W +: IN_W])
                                  + ext(data_i[(2*j+1)*IN_W +: IN_W])
                                  + {{(OUT_W-1){1'b0}}, (j == 0) & cin_i};
      end
      if (N_NODES % 2 == 1) begin
         data_d[(N_OUT-1)*OUT_W +: OUT_W] = ext(data_i[(N_NODES-1)*IN_W +: IN_W]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
      end else if (en_i) begin
         data_q <= data_d;
      end
   end

   assign data_o = data_q;

endmodule

// File: rtl/pipelined_adder_tree.sv
// Pipelined N-operand adder tree with carry-in; whole pipeline stalls on backpressure.
module pipelined_adder_tree
   import fir_pkg::*;
#(
   parameter int unsigned IN_DATAWIDTH = DefInDatawidth,
   parameter int unsigned N_INPUTS     = DefNInputs,
   parameter bit          SIGNED       = 1'b0
) (
   input logic                  clk,
   input logic                  rst,
   pipelined_adder_tree_if.slave bus
);

   localparam int unsigned LEVELS        = $clog2(N_INPUTS);
   localparam int unsigned OUT_DATAWIDTH = add_width(IN_DATAWIDTH, N_INPUTS);

   logic              advance;
   logic [LEVELS-1:0] valid_d, valid_q;

   assign advance = !valid_q[LEVELS-1] | bus.out_ready;

   for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
      localparam int unsigned NIn  = level_nodes(N_INPUTS, l);
      localparam int unsigned WIn  = IN_DATAWIDTH + l;
      localparam int unsigned NOut = level_nodes(N_INPUTS, l + 1);

      logic [NIn*WIn-1:0]      din;
      logic [NOut*(WIn+1)-1:0] dout;

      if (l == 0) begin : g_first
         assign din = bus.in_data;
      end else begin : g_next
         assign din = g_lvl[l-1].dout;
      end

      // cin rides with its operand set by entering only the first level.
      adder_tree_stage #(
         .IN_W    (WIn),
         .N_NODES (NIn),
         .SIGNED  (SIGNED)
      ) u_stage (
         .clk    (clk),
         .rst    (rst),
         .en_i   (advance),
         .cin_i  ((l == 0) ? bus.cin : 1'b0),
         .data_i (din),
         .data_o (dout)
      );
   end

   always_comb begin
      valid_d    = '0;
      valid_d[0] = bus.in_valid;
      for (int unsigned l = 1; l < LEVELS; l++) begin
         valid_d[l] = valid_q[l-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
      end else if (advance) begin
         valid_q <= valid_d;
      end
   end

   assign bus.in_ready  = advance;
   assign bus.out_valid = valid_q[LEVELS-1];
   assign bus.sum       = OUT_DATAWIDTH'(g_lvl[LEVELS-1].dout);

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Directed bench for pipelined_adder_tree: N=4 unsigned, N=2 unsigned, N=5 signed.
module tb_pipelined_adder_tree;

   logic clk;
   logic rst;

   int n_cmp = 0;
   int n_err = 0;

   pipelined_adder_tree_if #(.IN_DATAWIDTH(8), .N_INPUTS(4)) bus4 ();
   pipelined_adder_tree_if #(.IN_DATAWIDTH(8), .N_INPUTS(2)) bus2 ();
   pipelined_adder_tree_if #(.IN_DATAWIDTH(8), .N_INPUTS(5)) bus5 ();

   pipelined_adder_tree #(.IN_DATAWIDTH(8), .N_INPUTS(4), .SIGNED(1'b0)) u_dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4)
   );

   pipelined_adder_tree #(.IN_DATAWIDTH(8), .N_INPUTS(2), .SIGNED(1'b0)) u_dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   pipelined_adder_tree #(.IN_DATAWIDTH(8), .N_INPUTS(5), .SIGNED(1'b1)) u_dut5 (
      .clk (clk),
      .rst (rst),
      .bus (bus5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic signed [63:0] obs,
                        input logic signed [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic        mv [2];
      logic signed [63:0] exp_q [$];
      int          sent;
      int          recv;
      logic        pat [5];
      int          exp_s [5];

      pat   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      exp_s = '{4, 0, 12, 16, 0};

      rst = 1'b1;
      bus4.in_data = '0; bus4.cin = 1'b0; bus4.in_valid = 1'b0; bus4.out_ready = 1'b1;
      bus2.in_data = '0; bus2.cin = 1'b0; bus2.in_valid = 1'b0; bus2.out_ready = 1'b1;
      bus5.in_data = '0; bus5.cin = 1'b0; bus5.in_valid = 1'b0; bus5.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst4_valid", bus4.out_valid, 0);
      check("rst4_sum",   bus4.sum,       0);
      check("rst4_ready", bus4.in_ready,  1);
      check("rst2_valid", bus2.out_valid, 0);
      check("rst5_valid", bus5.out_valid, 0);
      check("rst5_sum",   $signed(bus5.sum), 0);

      // Unsigned N=4: 4*255 + 1.
      bus4.in_data  = {4{8'hff}};
      bus4.cin      = 1'b1;
      bus4.in_valid = 1'b1;
      tick();
      bus4.in_valid = 1'b0;
      check("u4_lat1_valid", bus4.out_valid, 0);
      tick();
      check("u4_max_valid", bus4.out_valid, 1);
      check("u4_max_sum",   bus4.sum,       1021);
      tick();
      check("u4_max_drain", bus4.out_valid, 0);

      // N=2 exhaustive doubling, one cycle latency.
      for (int i = 0; i <= 256; i++) begin
         bus2.in_valid = (i < 256);
         bus2.in_data  = {8'(i), 8'(i)};
         tick();
         if (i < 256) begin
            check("n2_valid", bus2.out_valid, 1);
            check("n2_sum",   bus2.sum,       2 * i);
         end else begin
            check("n2_drain", bus2.out_valid, 0);
         end
      end
      bus2.in_valid = 1'b0;

      // Signed N=5 extremes, back-to-back.
      bus5.in_data  = {5{8'h80}};
      bus5.cin      = 1'b0;
      bus5.in_valid = 1'b1;
      tick();
      bus5.in_data  = {5{8'h7f}};
      bus5.cin      = 1'b1;
      tick();
      bus5.in_valid = 1'b0;
      check("s5_lat2_valid", bus5.out_valid, 0);
      tick();
      check("s5_min_valid", bus5.out_valid, 1);
      check("s5_min_sum",   $signed(bus5.sum), -640);
      tick();
      check("s5_max_valid", bus5.out_valid, 1);
      check("s5_max_sum",   $signed(bus5.sum), 636);
      tick();
      check("s5_drain", bus5.out_valid, 0);

      // Backpressure: out_ready 1,0,0 repeating; scoreboard keeps order.
      mv[0] = 1'b0; mv[1] = 1'b0;
      sent = 0;
      recv = 0;
      for (int c = 0; c < 200 && recv < 10; c++) begin
         logic exp_adv;
         bus4.out_ready = (c % 3 == 0);
         bus4.in_valid  = (sent < 10);
         bus4.in_data   = {8'(sent + 3), 8'(sent + 2), 8'(sent + 1), 8'(sent)};
         bus4.cin       = sent[0];
         #1;
         exp_adv = !mv[1] | bus4.out_ready;
         check("bp_in_ready",  bus4.in_ready,  exp_adv);
         check("bp_out_valid", bus4.out_valid, mv[1]);
         if (mv[1]) begin
            if (exp_q.size() == 0) begin
               check("bp_underflow", 1, 0);
            end else begin
               check("bp_sum", bus4.sum, exp_q[0]);
               if (bus4.out_ready) begin
                  void'(exp_q.pop_front());
                  recv++;
               end
            end
         end
         if (bus4.in_valid && exp_adv) begin
            exp_q.push_back(4 * sent + 6 + (sent % 2));
            sent++;
         end
         if (exp_adv) begin
            mv[1] = mv[0];
            mv[0] = bus4.in_valid;
         end
         tick();
      end
      check("bp_recv", recv, 10);
      check("bp_left", exp_q.size(), 0);
      bus4.in_valid  = 1'b0;
      bus4.out_ready = 1'b1;
      bus4.cin       = 1'b0;
      tick();
      tick();
      check("bp_drain", bus4.out_valid, 0);

      // Bubbles: valid pattern reappears at the output two cycles later.
      for (int c = 0; c < 7; c++) begin
         bus4.in_valid = (c < 5) ? pat[c % 5] : 1'b0;
         bus4.in_data  = {4{8'(c + 1)}};
         tick();
         if (c >= 1 && c <= 5) begin
            check("bub_valid", bus4.out_valid, pat[c-1]);
            if (pat[c-1]) check("bub_sum", bus4.sum, exp_s[c-1]);
         end else begin
            check("bub_idle", bus4.out_valid, 0);
         end
      end

      // Reset with two sets in flight and the output stalled.
      bus4.out_ready = 1'b0;
      bus4.in_valid  = 1'b1;
      bus4.in_data   = {4{8'd10}};
      tick();
      bus4.in_data   = {4{8'd20}};
      tick();
      bus4.in_valid  = 1'b0;
      check("rm_pre_valid", bus4.out_valid, 1);
      check("rm_pre_sum",   bus4.sum,       40);
      check("rm_pre_ready", bus4.in_ready,  0);
      #3;
      rst = 1'b1;
      #1;
      check("rm_async_valid", bus4.out_valid, 0);
      check("rm_async_sum",   bus4.sum,       0);
      check("rm_async_ready", bus4.in_ready,  1);
      @(negedge clk);
      rst = 1'b0;
      bus4.out_ready = 1'b1;
      tick();
      check("rm_no_stale", bus4.out_valid, 0);
      bus4.in_valid = 1'b1;
      bus4.in_data  = {4{8'd5}};
      bus4.cin      = 1'b1;
      tick();
      bus4.in_valid = 1'b0;
      bus4.cin      = 1'b0;
      check("rm_new_lat1", bus4.out_valid, 0);
      tick();
      check("rm_new_valid", bus4.out_valid, 1);
      check("rm_new_sum",   bus4.sum,       21);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
